// File: rtl/univ_shift_reg_n_if.sv
// Port bundle for univ_shift_reg_n: parallel load, shift handshake and
// register observation signals. The controller drives through master, the
// register itself sits on slave.
interface univ_shift_reg_n_if #(
   parameter int unsigned N     = 4,
   parameter int unsigned CNT_W = 3
);
   logic [N-1:0]     I;
   logic             load;
   logic             start;
   logic [2:0]       mode;
   logic [CNT_W-1:0] cnt;
   logic             sin_r;
   logic             sin_l;
   logic [N-1:0]     Q;
   logic             busy;
   logic             done;
   logic             sout_l;
   logic             sout_r;

   modport master (
      output I, load, start, mode, cnt, sin_r, sin_l,
      input  Q, busy, done, sout_l, sout_r
   );

   modport slave (
      input  I, load, start, mode, cnt, sin_r, sin_l,
      output Q, busy, done, sout_l, sout_r
   );
endinterface

// File: rtl/univ_shift_reg_n.sv
// Universal N-bit register: one-cycle parallel load plus multi-cycle
// shift/rotate/arithmetic-shift operations run under a start/busy/done
// handshake. Mode and count are captured at start; serial inputs are
// sampled live on every step.
module univ_shift_reg_n #(
   parameter int unsigned N     = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic           clk,
   input  logic           rst,
   univ_shift_reg_n_if.slave bus
);

   localparam logic [2:0] ModeSll = 3'd0;
   localparam logic [2:0] ModeSrl = 3'd1;
   localparam logic [2:0] ModeRol = 3'd2;
   localparam logic [2:0] ModeRor = 3'd3;
   localparam logic [2:0] ModeSra = 3'd4;

   typedef enum logic [0:0] {
      StIdle,
      StShift
   } state_e;

   state_e           state_q, state_d;
   logic [N-1:0]     q_q, q_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [2:0]       op_q, op_d;
   logic             done_q, done_d;

   logic mode_ok;
   logic cnt_zero;
   logic last_step;

   // Modes 5..7 are reserved; a start carrying one of them is dropped.
   assign mode_ok   = (bus.mode <= ModeSra);
   assign cnt_zero  = (bus.cnt == '0);
   assign last_step = (rem_q == CNT_W'(1));

   // One single-bit step of the latched operation.
   function automatic logic [N-1:0] shift_step(input logic [2:0]   op,
                                               input logic [N-1:0] q,
                                               input logic         sl,
                                               input logic         sr);
      logic [N-1:0] r;
      r = q;
      case (op)
         ModeSll: r = {q[N-2:0], sr};
         ModeSrl: r = {sl, q[N-1:1]};
         ModeRol: r = {q[N-2:0], q[N-1]};
         ModeRor: r = {q[0], q[N-1:1]};
         ModeSra: r = {q[N-1], q[N-1:1]};
         default: r = q;
      endcase
      return r;
   endfunction

   // State and datapath registers; synchronous reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         q_q     <= '0;
         rem_q   <= '0;
         op_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
         done_q  <= done_d;
      end
   end

   // Next-state: leave IDLE only for a valid non-zero start not pre-empted by load.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (!bus.load && bus.start && mode_ok && !cnt_zero) begin
               state_d = StShift;
            end
         end
         StShift: begin
            if (last_step) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath next values: load/capture in IDLE, one step per clock in SHIFT.
   always_comb begin
      q_d    = q_q;
      rem_d  = rem_q;
      op_d   = op_q;
      done_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.load) begin
               q_d = bus.I;
            end else if (bus.start && mode_ok) begin
               if (cnt_zero) begin
                  // Zero-length operation completes immediately without touching Q.
                  done_d = 1'b1;
               end else begin
                  op_d  = bus.mode;
                  rem_d = bus.cnt;
               end
            end
         end
         StShift: begin
            q_d   = shift_step(op_q, q_q, bus.sin_l, bus.sin_r);
            rem_d = rem_q - CNT_W'(1);
            if (last_step) begin
               done_d = 1'b1;
            end
         end
         default: begin
            q_d = q_q;
         end
      endcase
   end

   // Outputs: all derived from registered state; serial outs tap Q directly.
   always_comb begin
      bus.Q      = q_q;
      bus.busy   = (state_q == StShift);
      bus.done   = done_q;
      bus.sout_l = q_q[N-1];
      bus.sout_r = q_q[0];
   end

`ifndef SYNTHESIS
   // done always follows a return to IDLE, so it can never overlap busy.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(bus.busy && bus.done));
      end
   end
`endif

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Bench for univ_shift_reg_n: directed test-plan sequences followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_univ_shift_reg_n;

   localparam int N     = 4;
   localparam int CNT_W = 3;
   localparam int Mask  = (1 << N) - 1;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   univ_shift_reg_n_if #(.N(N), .CNT_W(CNT_W)) bus ();

   univ_shift_reg_n #(.N(N), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: word value, steps left, latched op, done flag.
   int mq    = 0;
   int mrem  = 0;
   int mop   = 0;
   int mdone = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int step_word(input int op, input int q, input int sl, input int sr);
      case (op)
         0: return ((q << 1) | sr) & Mask;
         1: return (q >> 1) | (sl << (N - 1));
         2: return ((q << 1) | (q >> (N - 1))) & Mask;
         3: return (q >> 1) | ((q & 1) << (N - 1));
         4: return (q >> 1) | (q & (1 << (N - 1)));
         default: return q;
      endcase
   endfunction

   // Apply the rules for one clock edge, using the inputs present at that edge.
   task automatic model_edge();
      int md;
      int ct;
      md = int'(bus.mode);
      ct = int'(bus.cnt);
      if (rst) begin
         mq = 0; mrem = 0; mop = 0; mdone = 0;
      end else if (mrem > 0) begin
         mq    = step_word(mop, mq, int'(bus.sin_l), int'(bus.sin_r));
         mrem  = mrem - 1;
         mdone = (mrem == 0) ? 1 : 0;
      end else begin
         mdone = 0;
         if (bus.load) begin
            mq = int'(bus.I) & Mask;
         end else if (bus.start && md <= 4) begin
            if (ct == 0) mdone = 1;
            else begin
               mop  = md;
               mrem = ct;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("q", 32'(bus.Q), 32'(mq));
      check("busy", 32'(bus.busy), 32'(mrem != 0));
      check("done", 32'(bus.done), 32'(mdone));
      check("sout_l", 32'(bus.sout_l), 32'((mq >> (N - 1)) & 1));
      check("sout_r", 32'(bus.sout_r), 32'(mq & 1));
   endtask

   task automatic do_load(input logic [N-1:0] val);
      bus.load = 1'b1;
      bus.I    = val;
      tick();
      bus.load = 1'b0;
   endtask

   task automatic start_op(input logic [2:0] md, input logic [CNT_W-1:0] ct);
      bus.start = 1'b1;
      bus.mode  = md;
      bus.cnt   = ct;
      tick();
      bus.start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      bus.I     = '0;
      bus.load  = 1'b0;
      bus.start = 1'b0;
      bus.mode  = '0;
      bus.cnt   = '0;
      bus.sin_r = 1'b0;
      bus.sin_l = 1'b0;

      // Reset then load.
      tick();
      tick();
      check("rst_q", 32'(bus.Q), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_done", 32'(bus.done), 32'h0);
      rst = 1'b0;
      do_load(4'b1011);
      check("load_q", 32'(bus.Q), 32'b1011);
      check("load_sout_l", 32'(bus.sout_l), 32'h1);
      check("load_sout_r", 32'(bus.sout_r), 32'h1);

      // ROL by 2.
      start_op(3'd2, 3'd2);
      check("rol_busy_e0", 32'(bus.busy), 32'h1);
      tick();
      check("rol_e1", 32'(bus.Q), 32'b0111);
      check("rol_busy_e1", 32'(bus.busy), 32'h1);
      tick();
      check("rol_e2", 32'(bus.Q), 32'b1110);
      check("rol_done", 32'(bus.done), 32'h1);
      check("rol_busy_e2", 32'(bus.busy), 32'h0);
      tick();
      check("rol_done_drop", 32'(bus.done), 32'h0);

      // SRA by 3 and by 7.
      do_load(4'b1000);
      start_op(3'd4, 3'd3);
      tick();
      check("sra_e1", 32'(bus.Q), 32'b1100);
      tick();
      check("sra_e2", 32'(bus.Q), 32'b1110);
      tick();
      check("sra_e3", 32'(bus.Q), 32'b1111);
      check("sra_done", 32'(bus.done), 32'h1);
      do_load(4'b1000);
      start_op(3'd4, 3'd7);
      repeat (7) tick();
      check("sra7_q", 32'(bus.Q), 32'b1111);
      check("sra7_done", 32'(bus.done), 32'h1);
      tick();

      // SLL with sin_r, then SRL with live sin_l.
      do_load(4'b0011);
      bus.sin_r = 1'b1;
      start_op(3'd0, 3'd1);
      tick();
      check("sll_q", 32'(bus.Q), 32'b0111);
      bus.sin_r = 1'b0;
      bus.sin_l = 1'b1;
      start_op(3'd1, 3'd2);
      tick();
      check("srl_e1", 32'(bus.Q), 32'b1011);
      bus.sin_l = 1'b0;
      tick();
      check("srl_e2", 32'(bus.Q), 32'b0101);
      tick();

      // Load and start together: load wins.
      bus.load  = 1'b1;
      bus.I     = 4'b1010;
      bus.start = 1'b1;
      bus.mode  = 3'd2;
      bus.cnt   = 3'd3;
      tick();
      bus.load  = 1'b0;
      bus.start = 1'b0;
      check("ldst_q", 32'(bus.Q), 32'b1010);
      check("ldst_busy", 32'(bus.busy), 32'h0);

      // Load during SHIFT is ignored.
      start_op(3'd2, 3'd3);
      bus.load = 1'b1;
      bus.I    = 4'b1111;
      repeat (3) tick();
      bus.load = 1'b0;
      check("ldshift_q", 32'(bus.Q), 32'b0101);
      check("ldshift_done", 32'(bus.done), 32'h1);

      // Reserved mode.
      start_op(3'd6, 3'd3);
      check("rsv_busy", 32'(bus.busy), 32'h0);
      check("rsv_done", 32'(bus.done), 32'h0);
      tick();
      check("rsv_q", 32'(bus.Q), 32'b0101);

      // cnt = 0.
      start_op(3'd1, 3'd0);
      check("cnt0_done", 32'(bus.done), 32'h1);
      check("cnt0_busy", 32'(bus.busy), 32'h0);
      check("cnt0_q", 32'(bus.Q), 32'b0101);
      tick();
      check("cnt0_drop", 32'(bus.done), 32'h0);

      // Reset mid-operation.
      do_load(4'b1001);
      start_op(3'd3, 3'd5);
      tick();
      check("ror_e1", 32'(bus.Q), 32'b1100);
      tick();
      check("ror_e2", 32'(bus.Q), 32'b0110);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_q", 32'(bus.Q), 32'h0);
      check("abort_busy", 32'(bus.busy), 32'h0);
      check("abort_done", 32'(bus.done), 32'h0);
      tick();
      check("abort_nodone", 32'(bus.done), 32'h0);
      do_load(4'b0101);
      check("abort_load", 32'(bus.Q), 32'b0101);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         rst       = ($urandom_range(0, 59) == 0);
         bus.load  = ($urandom_range(0, 6) == 0);
         bus.start = ($urandom_range(0, 2) == 0);
         bus.mode  = 3'($urandom_range(0, 7));
         bus.cnt   = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
         bus.I     = N'($urandom);
         bus.sin_r = 1'($urandom);
         bus.sin_l = 1'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
